// File: rtl/stump_io_timer.sv
// stump_io_timer: 8-word memory-mapped window holding a prescaled 16-bit
// countdown timer, a GPIO output register and a synchronised GPIO input.
// Accesses outside the window pass straight through to RAM.
module stump_io_timer #(
    parameter logic [15:0] BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        mem_wen,
    input  logic        mem_ren,
    input  logic [15:0] ram_rdata,
    output logic        ram_wen,
    output logic        ram_ren,
    output logic [15:0] data_in,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        irq
);

    localparam logic [2:0] OffCtrl    = 3'd0;
    localparam logic [2:0] OffLoad    = 3'd1;
    localparam logic [2:0] OffCount   = 3'd2;
    localparam logic [2:0] OffStatus  = 3'd3;
    localparam logic [2:0] OffPresc   = 3'd4;
    localparam logic [2:0] OffGpioOut = 3'd5;
    localparam logic [2:0] OffGpioIn  = 3'd6;

    // ctrl bit0 = en, bit1 = reload, bit2 = irq_en
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  pc_q, pc_d;
    logic        expired_q, expired_d;
    logic [15:0] gpio_out_q, gpio_out_d;
    logic [15:0] sync1_q, sync2_q;

    logic        hit;
    logic [2:0]  offset;
    logic        wr;
    logic        tick;
    logic        expire;
    logic [15:0] reg_rdata;

    assign hit      = (address[15:3] == BASE[15:3]);
    assign offset   = address[2:0];
    assign wr       = hit & mem_wen;
    assign ram_wen  = mem_wen & ~hit;
    assign ram_ren  = mem_ren & ~hit;
    assign tick     = ctrl_q[0] & (pc_q == presc_q);
    assign expire   = tick & (count_q == 16'd0);
    assign gpio_out = gpio_out_q;
    assign irq      = expired_q & ctrl_q[2];

    // Next-state: timer/prescaler progress first, CPU writes override afterwards.
    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        presc_d    = presc_q;
        pc_d       = pc_q;
        expired_d  = expired_q;
        gpio_out_d = gpio_out_q;

        if (ctrl_q[0]) begin
            pc_d = tick ? 8'd0 : pc_q + 8'd1;
        end

        if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                expired_d = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        if (wr) begin
            case (offset)
                OffCtrl: begin
                    ctrl_d = data_out[2:0];
                    // Enabling from idle restarts the prescale period.
                    if (!ctrl_q[0] && data_out[0]) begin
                        pc_d = 8'd0;
                    end
                end
                OffLoad:    load_d  = data_out;
                OffCount:   count_d = data_out;
                OffStatus: begin
                    // A same-cycle expiry keeps the flag set.
                    if (data_out[0] && !expire) begin
                        expired_d = 1'b0;
                    end
                end
                OffPresc:   presc_d    = data_out[7:0];
                OffGpioOut: gpio_out_d = data_out;
                default: ;
            endcase
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= 3'd0;
            load_q     <= 16'd0;
            count_q    <= 16'd0;
            presc_q    <= 8'd0;
            pc_q       <= 8'd0;
            expired_q  <= 1'b0;
            gpio_out_q <= 16'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            pc_q       <= pc_d;
            expired_q  <= expired_d;
            gpio_out_q <= gpio_out_d;
        end
    end

    // Two-flop synchroniser for the asynchronous GPIO inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 16'd0;
            sync2_q <= 16'd0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    // Register read mux and return-path select between window and RAM.
    always_comb begin
        reg_rdata = 16'd0;
        case (offset)
            OffCtrl:    reg_rdata = {13'd0, ctrl_q};
            OffLoad:    reg_rdata = load_q;
            OffCount:   reg_rdata = count_q;
            OffStatus:  reg_rdata = {14'd0, ctrl_q[0], expired_q};
            OffPresc:   reg_rdata = {8'd0, presc_q};
            OffGpioOut: reg_rdata = gpio_out_q;
            OffGpioIn:  reg_rdata = sync2_q;
            default:    reg_rdata = 16'd0;
        endcase
        data_in = (hit & mem_ren) ? reg_rdata : ram_rdata;
    end

endmodule

// File: tb/tb_stump_io_timer.sv
// Randomised bench for stump_io_timer against a cycle-level behavioural model.
module tb_stump_io_timer;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        mem_wen;
    logic        mem_ren;
    logic [15:0] ram_rdata;
    logic        ram_wen;
    logic        ram_ren;
    logic [15:0] data_in;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] last_rd;

    stump_io_timer #(.BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .data_out  (data_out),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .ram_rdata (ram_rdata),
        .ram_wen   (ram_wen),
        .ram_ren   (ram_ren),
        .data_in   (data_in),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Behavioural model state.
    logic        m_en, m_reload, m_irqen, m_exp;
    logic [15:0] m_load, m_count, m_gout;
    logic [7:0]  m_presc;
    logic [7:0]  m_since_tick;  // enabled cycles elapsed since the last tick
    logic [15:0] m_hist [2];    // gpio_in samples taken at the last two edges

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_reload = 0; m_irqen = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_gout = 0; m_presc = 0; m_since_tick = 0;
        m_hist[0] = 0; m_hist[1] = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] off);
        case (off)
            3'd0: return {13'd0, m_irqen, m_reload, m_en};
            3'd1: return m_load;
            3'd2: return m_count;
            3'd3: return {14'd0, m_en, m_exp};
            3'd4: return {8'd0, m_presc};
            3'd5: return m_gout;
            3'd6: return m_hist[1];
            default: return 16'd0;
        endcase
    endfunction

    // Advance the model across one rising edge using the bus inputs present at it.
    task automatic model_step();
        logic is_hit, tick, expiry, was_en;
        logic [2:0] off;
        is_hit = (address[15:3] == BASE[15:3]);
        off    = address[2:0];
        tick   = m_en && (m_since_tick == m_presc);
        expiry = tick && (m_count == 16'd0);
        was_en = m_en;
        if (m_en) m_since_tick = tick ? 8'd0 : m_since_tick + 8'd1;
        if (tick) begin
            if (m_count != 0) m_count = m_count - 16'd1;
            else begin
                m_exp = 1;
                if (m_reload) m_count = m_load;
                else m_en = 0;
            end
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = gpio_in;
        if (is_hit && mem_wen) begin
            case (off)
                3'd0: begin
                    if (!was_en && data_out[0]) m_since_tick = 0;
                    m_en = data_out[0]; m_reload = data_out[1]; m_irqen = data_out[2];
                end
                3'd1: m_load = data_out;
                3'd2: m_count = data_out;
                3'd3: if (data_out[0] && !expiry) m_exp = 0;
                3'd4: m_presc = data_out[7:0];
                3'd5: m_gout = data_out;
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive, compare on the falling edge, step the model on the rising edge.
    task automatic bus(input logic [15:0] a, input logic [15:0] wd, input logic w, input logic r);
        logic is_hit;
        logic [15:0] exp_din;
        address   = a;
        data_out  = wd;
        mem_wen   = w;
        mem_ren   = r;
        ram_rdata = 16'($urandom);
        @(negedge clk);
        is_hit  = (a[15:3] == BASE[15:3]);
        exp_din = (is_hit && r) ? model_read(a[2:0]) : ram_rdata;
        last_rd = data_in;
        check("data_in", data_in, exp_din);
        check("ram_wen", {15'd0, ram_wen}, {15'd0, w && !is_hit});
        check("ram_ren", {15'd0, ram_ren}, {15'd0, r && !is_hit});
        check("irq", {15'd0, irq}, {15'd0, m_exp && m_irqen});
        check("gpio_out", gpio_out, m_gout);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] d);
        bus(BASE | {13'd0, off}, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [2:0] off);
        bus(BASE | {13'd0, off}, 16'd0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] a, d;
        logic [2:0]  off;
        rst = 1'b0;
        address = 0; data_out = 0; mem_wen = 0; mem_ren = 0; ram_rdata = 0; gpio_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_irq", {15'd0, irq}, 16'd0);
        check("reset_gpio_out", gpio_out, 16'd0);
        rst = 1'b1;

        // Reset state of the whole window, then RAM pass-through.
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            check("reset_reg", last_rd, 16'd0);
        end
        address = 16'h1234; mem_ren = 1; mem_wen = 0; ram_rdata = 16'hBEEF;
        #1;
        check("passthru_data", data_in, 16'hBEEF);
        check("passthru_ren", {15'd0, ram_ren}, 16'd1);
        bus(16'h1234, 16'd0, 1'b0, 1'b1);

        // One-shot: PRESC=1, COUNT=3, enable with irq.
        wr(3'd4, 16'd1);
        wr(3'd2, 16'd3);
        wr(3'd0, 16'd5);
        repeat (10) rd(3'd2);
        rd(3'd0);
        check("oneshot_ctrl", last_rd, 16'd4);
        check("oneshot_irq", {15'd0, irq}, 16'd1);

        // Auto-reload with periodic STATUS clears, then write/tick collision.
        wr(3'd3, 16'd1);
        wr(3'd1, 16'd2);
        wr(3'd2, 16'd2);
        wr(3'd4, 16'd0);
        wr(3'd0, 16'd3);
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) wr(3'd3, 16'd1);
            else rd(3'd2);
        end
        wr(3'd2, 16'h0100);
        rd(3'd2);
        check("collide_first", last_rd, 16'h0100);
        rd(3'd2);
        check("collide_second", last_rd, 16'h00FF);

        // GPIO.
        wr(3'd5, 16'hA5A5);
        check("gpio_out_a5", gpio_out, 16'hA5A5);
        gpio_in = 16'h3C3C;
        rd(3'd6);
        rd(3'd6);
        rd(3'd6);
        check("gpio_in_sync", last_rd, 16'h3C3C);
        wr(3'd6, 16'hFFFF);
        rd(3'd6);
        check("gpio_in_ro", last_rd, 16'h3C3C);

        // Randomised traffic biased toward the window and short timer values.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 8) a = BASE | 16'($urandom_range(0, 7));
            else a = 16'($urandom);
            off = a[2:0];
            case (off)
                3'd1, 3'd2: d = 16'($urandom_range(0, 5));
                3'd4:       d = 16'($urandom_range(0, 3));
                3'd3:       d = 16'($urandom_range(0, 3));
                default:    d = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) gpio_in = 16'($urandom);
            bus(a, d, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while a reloading timer runs with irq raised.
        wr(3'd4, 16'd0);
        wr(3'd1, 16'd5);
        wr(3'd2, 16'd5);
        wr(3'd0, 16'd7);
        repeat (8) rd(3'd2);
        check("pre_reset_irq", {15'd0, irq}, 16'd1);
        address = BASE | 16'd2; mem_ren = 1; mem_wen = 0;
        #3;
        rst = 1'b0;
        #1;
        check("async_count", data_in, 16'd0);
        check("async_irq", {15'd0, irq}, 16'd0);
        check("async_gpio_out", gpio_out, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd(3'd2);
            check("idle_count", last_rd, 16'd0);
        end
        rd(3'd0);
        check("idle_ctrl", last_rd, 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
